// File: rtl/dice_pkg.sv
// Shared types, constants and rule helpers for the parametrised dice game controller.
package dice_pkg;

  typedef enum logic [2:0] {
    ST_COME_OUT = 3'd0,
    ST_ROLLING  = 3'd1,
    ST_EVAL     = 3'd2,
    ST_POINT    = 3'd3,
    ST_WON      = 3'd4,
    ST_LOST     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OUT_POINT = 2'd0,
    OUT_WON   = 2'd1,
    OUT_LOST  = 2'd2
  } outcome_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

  function automatic logic [3:0] clamp_face(input logic [3:0] val, input int unsigned sides);
    logic [3:0] res;
    if ((val == 4'd0) || (32'(val) > sides)) begin
      res = 4'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

  function automatic logic [3:0] advance_face(input logic [3:0] val, input int unsigned sides);
    logic [3:0] res;
    if (32'(val) >= sides) begin
      res = 4'd1;
    end else begin
      res = val + 4'd1;
    end
    return res;
  endfunction

  function automatic outcome_e eval_outcome(
    input int unsigned sum,
    input int unsigned point,
    input int unsigned win_a,
    input int unsigned win_b,
    input int unsigned lose_max,
    input int unsigned max_sum
  );
    outcome_e res;
    if (point == 32'd0) begin
      if ((sum == win_a) || (sum == win_b)) begin
        res = OUT_WON;
      end else if ((sum <= lose_max) || (sum == max_sum)) begin
        res = OUT_LOST;
      end else begin
        res = OUT_POINT;
      end
    end else begin
      if (sum == point) begin
        res = OUT_WON;
      end else if (sum == win_a) begin
        res = OUT_LOST;
      end else begin
        res = OUT_POINT;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability counter for an active-low push button.
// level is the debounced button line (1 = released); press/release pulse for one cycle.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 32'd1)) begin
        level_d = sync_q[1];
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
    press_d = level_q & ~level_d;
    rel_d   = ~level_q & level_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/dice_game_core.sv
// Dice game controller: debounced hold-to-tumble rolling, direct dice load and
// come-out/point rule evaluation with saturating win/loss tallies.
module dice_game_core
  import dice_pkg::*;
#(
  parameter int unsigned NUM_DICE        = 2,
  parameter int unsigned SIDES           = 6,
  parameter int unsigned WIN_A           = 7,
  parameter int unsigned WIN_B           = 11,
  parameter int unsigned LOSE_MAX        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SUMW            = $clog2(NUM_DICE * SIDES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  roll_n,
  input  logic                  load,
  input  logic [4*NUM_DICE-1:0] load_vals,
  output logic [4*NUM_DICE-1:0] dice,
  output logic [SUMW-1:0]       sum,
  output logic [SUMW-1:0]       point,
  output logic                  win,
  output logic                  loss,
  output logic                  rolling,
  output logic [7:0]            win_count,
  output logic [7:0]            loss_count
);

  localparam int unsigned MAX_SUM = NUM_DICE * SIDES;

  logic db_level, db_press, db_release;

  state_e                     state_q, state_d;
  logic [NUM_DICE-1:0][3:0]   dice_q, dice_d;
  logic [SUMW-1:0]            point_q, point_d;
  logic [SUMW-1:0]            sum_s;
  logic                       win_q, win_d, loss_q, loss_d, rolling_q, rolling_d;
  logic [7:0]                 win_cnt_q, win_cnt_d, loss_cnt_q, loss_cnt_d;
  logic [15:0]                lfsr_q, lfsr_d;
  logic                       idle_s, new_game_s;
  outcome_e                   outcome_s;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_roll_db (
    .clock         (clock),
    .reset         (reset),
    .btn_n         (roll_n),
    .level         (db_level),
    .press         (db_press),
    .release_pulse (db_release)
  );

  always_comb begin
    sum_s = '0;
    for (int i = 0; i < int'(NUM_DICE); i++) begin
      sum_s = sum_s + SUMW'(dice_q[i]);
    end
  end

  assign idle_s     = (state_q == ST_COME_OUT) || (state_q == ST_POINT) ||
                      (state_q == ST_WON)      || (state_q == ST_LOST);
  assign new_game_s = ((state_q == ST_WON) || (state_q == ST_LOST)) && (load || db_press);
  assign outcome_s  = eval_outcome(32'(sum_s), 32'(point_q), WIN_A, WIN_B, LOSE_MAX, MAX_SUM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_COME_OUT;
    end else begin
      state_q <= state_d;
    end
  end

  // Load has priority over a coincident press; the matching release then lands outside ROLLING.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COME_OUT, ST_POINT, ST_WON, ST_LOST: begin
        if (load) begin
          state_d = ST_EVAL;
        end else if (db_press) begin
          state_d = ST_ROLLING;
        end else begin
          state_d = state_q;
        end
      end
      ST_ROLLING: begin
        if (db_release) begin
          state_d = ST_EVAL;
        end else begin
          state_d = ST_ROLLING;
        end
      end
      ST_EVAL: begin
        case (outcome_s)
          OUT_WON:   state_d = ST_WON;
          OUT_LOST:  state_d = ST_LOST;
          OUT_POINT: state_d = ST_POINT;
          default:   state_d = ST_COME_OUT;
        endcase
      end
      default: state_d = ST_COME_OUT;
    endcase
  end

  always_comb begin
    dice_d     = dice_q;
    point_d    = point_q;
    win_d      = win_q;
    loss_d     = loss_q;
    win_cnt_d  = win_cnt_q;
    loss_cnt_d = loss_cnt_q;
    lfsr_d     = lfsr_next(lfsr_q);
    rolling_d  = (state_d == ST_ROLLING);

    if (new_game_s) begin
      point_d = '0;
      win_d   = 1'b0;
      loss_d  = 1'b0;
    end else begin
      point_d = point_q;
    end

    // db_level is already high in the release cycle, so the dice freeze there.
    if (idle_s && load) begin
      for (int i = 0; i < int'(NUM_DICE); i++) begin
        dice_d[i] = clamp_face(load_vals[4*i +: 4], SIDES);
      end
    end else if ((state_q == ST_ROLLING) && !db_level) begin
      for (int i = 0; i < int'(NUM_DICE); i++) begin
        if (lfsr_q[i]) begin
          dice_d[i] = advance_face(dice_q[i], SIDES);
        end else begin
          dice_d[i] = dice_q[i];
        end
      end
    end else begin
      dice_d = dice_q;
    end

    if (state_q == ST_EVAL) begin
      case (outcome_s)
        OUT_WON: begin
          win_d     = 1'b1;
          win_cnt_d = (win_cnt_q == 8'd255) ? 8'd255 : win_cnt_q + 8'd1;
        end
        OUT_LOST: begin
          loss_d     = 1'b1;
          loss_cnt_d = (loss_cnt_q == 8'd255) ? 8'd255 : loss_cnt_q + 8'd1;
        end
        OUT_POINT: begin
          if (point_q == '0) begin
            point_d = sum_s;
          end else begin
            point_d = point_q;
          end
        end
        default: point_d = point_q;
      endcase
    end else begin
      win_cnt_d = win_cnt_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dice_q     <= {NUM_DICE{4'd1}};
      point_q    <= '0;
      win_q      <= 1'b0;
      loss_q     <= 1'b0;
      rolling_q  <= 1'b0;
      win_cnt_q  <= 8'd0;
      loss_cnt_q <= 8'd0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      dice_q     <= dice_d;
      point_q    <= point_d;
      win_q      <= win_d;
      loss_q     <= loss_d;
      rolling_q  <= rolling_d;
      win_cnt_q  <= win_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      lfsr_q     <= lfsr_d;
    end
  end

  assign dice       = dice_q;
  assign sum        = sum_s;
  assign point      = point_q;
  assign win        = win_q;
  assign loss       = loss_q;
  assign rolling    = rolling_q;
  assign win_count  = win_cnt_q;
  assign loss_count = loss_cnt_q;

endmodule

// File: tb/tb_dice_game_core.sv
// Self-checking bench for dice_game_core: directed rule scenarios, random loads,
// a held roll, a glitch, reset mid-roll and tally saturation against a rules model.
module tb_dice_game_core;

  localparam int ND    = 2;
  localparam int SD    = 6;
  localparam int SUMW  = $clog2(ND * SD + 1);

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            roll_n = 1'b1;
  logic            load = 1'b0;
  logic [4*ND-1:0] load_vals = '0;
  logic [4*ND-1:0] dice;
  logic [SUMW-1:0] sum, point;
  logic            win, loss, rolling;
  logic [7:0]      win_count, loss_count;

  int tests = 0;
  int fails = 0;

  // reference model state
  int m_dice [ND];
  int m_point, m_wc, m_lc;
  bit m_win, m_loss;

  dice_game_core #(
    .NUM_DICE(ND), .SIDES(SD), .WIN_A(7), .WIN_B(11), .LOSE_MAX(3), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .roll_n(roll_n), .load(load), .load_vals(load_vals),
    .dice(dice), .sum(sum), .point(point), .win(win), .loss(loss), .rolling(rolling),
    .win_count(win_count), .loss_count(loss_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int die(input int i);
    logic [4*ND-1:0] d;
    d = dice;
    return int'(d[4*i +: 4]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_dice[i] = 1;
    m_point = 0; m_wc = 0; m_lc = 0; m_win = 0; m_loss = 0;
  endtask

  task automatic model_new_game();
    if (m_win || m_loss) begin
      m_point = 0; m_win = 0; m_loss = 0;
    end
  endtask

  // craps rules applied to the model's dice
  task automatic model_eval();
    int s;
    s = 0;
    for (int i = 0; i < ND; i++) s += m_dice[i];
    if (m_point == 0) begin
      if (s == 7 || s == 11) m_win = 1;
      else if (s <= 3 || s == ND * SD) m_loss = 1;
      else m_point = s;
    end else begin
      if (s == m_point) m_win = 1;
      else if (s == 7) m_loss = 1;
    end
    if (m_win && m_wc < 255 && s > 0 && (s == m_point || s == 7 || s == 11)) m_wc = m_wc;
  endtask

  task automatic model_tally(input bit was_win, input bit was_loss);
    if (m_win && !was_win && m_wc < 255) m_wc++;
    if (m_loss && !was_loss && m_lc < 255) m_lc++;
  endtask

  task automatic check_all(input string tag);
    int s;
    s = 0;
    for (int i = 0; i < ND; i++) begin
      chk({tag, "_dice"}, die(i), m_dice[i]);
      s += m_dice[i];
    end
    chk({tag, "_sum"}, 32'(sum), s);
    chk({tag, "_point"}, 32'(point), m_point);
    chk({tag, "_win"}, 32'(win), 32'(m_win));
    chk({tag, "_loss"}, 32'(loss), 32'(m_loss));
    chk({tag, "_wcount"}, 32'(win_count), m_wc);
    chk({tag, "_lcount"}, 32'(loss_count), m_lc);
    chk({tag, "_rolling"}, 32'(rolling), 0);
  endtask

  task automatic do_load(input string tag, input int v0, input int v1);
    @(negedge clock);
    load = 1'b1;
    load_vals = {4'(v1), 4'(v0)};
    model_new_game();
    m_dice[0] = (v0 < 1 || v0 > SD) ? 1 : v0;
    m_dice[1] = (v1 < 1 || v1 > SD) ? 1 : v1;
    @(negedge clock);
    load = 1'b0;
    chk({tag, "_eval_d0"}, die(0), m_dice[0]);
    chk({tag, "_eval_d1"}, die(1), m_dice[1]);
    model_eval();
    model_tally(1'b0, 1'b0);
    @(negedge clock);
    check_all(tag);
  endtask

  task automatic do_roll(input int hold);
    int k, changes;
    logic [4*ND-1:0] prev;
    @(negedge clock);
    roll_n = 1'b0;
    k = 0;
    while (rolling !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("roll_start", 32'(rolling), 1);
    model_new_game();
    chk("roll_win_clear", 32'(win), 32'(m_win));
    chk("roll_loss_clear", 32'(loss), 32'(m_loss));
    changes = 0;
    prev = dice;
    for (int c = 0; c < hold; c++) begin
      if (c == 10) begin
        load = 1'b1;
        load_vals = {4'd4, 4'd3};
      end else begin
        load = 1'b0;
      end
      @(negedge clock);
      for (int i = 0; i < ND; i++) chk("roll_range", 32'(die(i) >= 1 && die(i) <= SD), 1);
      chk("roll_held", 32'(rolling), 1);
      if (dice != prev) changes++;
      prev = dice;
    end
    load = 1'b0;
    chk("roll_changing", 32'(changes >= hold / 5), 1);
    roll_n = 1'b1;
    k = 0;
    while (rolling !== 1'b0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    chk("roll_stop", 32'(rolling), 0);
    // the frozen faces are the random input to the rules model
    for (int i = 0; i < ND; i++) m_dice[i] = die(i);
    model_eval();
    model_tally(1'b0, 1'b0);
    @(negedge clock);
    check_all("roll_result");
    repeat (5) @(negedge clock);
    check_all("roll_stable");
  endtask

  initial begin
    int v0, v1;
    model_reset();
    repeat (3) @(negedge clock);
    check_all("reset");
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_all("idle");

    do_load("natural7", 3, 4);
    do_load("craps2", 1, 1);
    do_load("craps12", 6, 6);
    do_load("point5", 2, 3);
    do_load("point_miss", 1, 3);
    do_load("point_hit", 4, 1);
    do_load("point8", 4, 4);
    do_load("seven_out", 3, 4);
    do_load("natural11", 5, 6);
    do_load("clamp", 0, 9);

    for (int n = 0; n < 40; n++) begin
      v0 = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, SD)) : int'($urandom_range(0, 15));
      v1 = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, SD)) : int'($urandom_range(0, 15));
      do_load("rand", v0, v1);
    end

    do_roll(50);
    do_load("point_ctx", 2, 2);
    do_roll(30);

    // a two-cycle glitch must not start a roll
    @(negedge clock);
    roll_n = 1'b0;
    repeat (2) @(negedge clock);
    roll_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      chk("glitch_no_roll", 32'(rolling), 0);
    end
    check_all("glitch");

    // reset in the middle of a roll
    @(negedge clock);
    roll_n = 1'b0;
    repeat (20) @(negedge clock);
    chk("pre_reset_rolling", 32'(rolling), 1);
    reset = 1'b1;
    model_reset();
    #1;
    check_all("reset_mid_roll");
    roll_n = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    check_all("after_reset");

    for (int n = 0; n < 256; n++) do_load("saturate", 3, 4);
    chk("wcount_sat", 32'(win_count), 255);
    do_load("lose_after_sat", 1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dice_game_core.md
# dice_game_core

Parametrised successor to the board-level dice game controller: N dice with S sides, internal button synchroniser/debouncer, hold-to-tumble rolling, and a generalised come-out/point rule set whose defaults reproduce two-dice craps. Adds win/loss tallies and a direct dice-load port for demo and verification. Sits between the raw board buttons and the seven-segment/LED drivers; display decoding stays outside.

## Interface

- NUM_DICE, 2, number of dice (2..4)
- SIDES, 6, faces per die (2..9, single display digit)
- WIN_A, 7, come-out natural and point-phase losing sum
- WIN_B, 11, second come-out natural
- LOSE_MAX, 3, come-out sums <= this lose
- DEBOUNCE_CYCLES, 250000, stable cycles required on roll_n
- SUMW, $clog2(NUM_DICE*SIDES+1), sum/point width (derived)

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- roll_n  in  1  raw roll button, active-low, asynchronous
- load  in  1  one-cycle load strobe, active-high
- load_vals  in  4*NUM_DICE  die values for load, die 0 in [3:0], each 1..SIDES
- dice  out  4*NUM_DICE  current face values, die 0 in [3:0]
- sum  out  SUMW  sum of dice
- point  out  SUMW  established point, 0 when none
- win  out  1  game won (held)
- loss  out  1  game lost (held)
- rolling  out  1  dice tumbling
- win_count  out  8  saturating game-win tally
- loss_count  out  8  saturating game-loss tally

## Operation

- Reset: every die = 1, sum = NUM_DICE, point = 0, win = loss = rolling = 0, counts = 0, LFSR = 16'hACE1, state COME_OUT, debounced level = released.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle.
- States: COME_OUT, ROLLING, EVAL, POINT, WON, LOST.
- Debounced press edge in COME_OUT/POINT/WON/LOST -> ROLLING. From WON/LOST, point, win and loss clear on entry to ROLLING (new game); from POINT, point is kept.
- ROLLING: rolling = 1; die i advances 1..SIDES (SIDES wraps to 1) on each cycle LFSR bit i is 1.
- Debounced release edge in ROLLING -> dice freeze, go EVAL.
- load = 1 in COME_OUT/POINT/WON/LOST: dice <= load_vals, go EVAL (point game context retained as for a press). load ignored in ROLLING/EVAL. Out-of-range load value (0 or >SIDES) is clamped to 1.
- EVAL, point == 0 (come-out): sum == WIN_A or WIN_B -> WON; sum <= LOSE_MAX or sum == NUM_DICE*SIDES -> LOST; else point <= sum, POINT.
- EVAL, point != 0: sum == point -> WON; sum == WIN_A -> LOST; else POINT.
- Entering WON: win = 1, win_count +1 (saturate at 255). Entering LOST: loss = 1, loss_count +1 (saturate).
- sum is combinational from dice registers, zero-extended to SUMW.

## Timing

- roll_n: 2-flop synchroniser, then counter; debounced level changes after DEBOUNCE_CYCLES consecutive cycles of a differing synchronised value. Press edge visible 2 + DEBOUNCE_CYCLES cycles after a clean button transition.
- Release edge cycle N: dice frozen at end of N; EVAL in N+1; win/loss/point/counts valid at N+2.
- load at cycle N: dice updated at N+1 (EVAL), results at N+2.
- load and press edge same cycle: load wins, press ignored; the later release is ignored outside ROLLING.
- Glitches shorter than DEBOUNCE_CYCLES: no effect.
- reset asserted any time, including mid-ROLLING or EVAL: immediate return to reset values; no partial count update.

## Structure

- Package dice_pkg: state enum, LFSR seed and tap constants, rule-evaluation function (sum, point, parameters -> outcome).
- Sub-module button_debounce (synchroniser + counter, parameter DEBOUNCE_CYCLES, outputs level and press/release pulses); instantiate once for roll_n.

## Test plan

Run with DEBOUNCE_CYCLES = 4.
- load dice {3,4} in COME_OUT -> sum 7, win = 1, point 0, win_count 1, two cycles after load.
- load {1,1} -> loss = 1, loss_count 1; then load {6,6} from LOST -> new game, loss again, loss_count 2.
- load {2,3} -> point 5, POINT; load {1,3} -> stays POINT; load {4,1} -> win = 1, point retained 5 until next game.
- point 8 established, then load {3,4} -> loss = 1.
- hold roll_n low 50 cycles: rolling = 1, all dice in 1..SIDES and changing; release -> rolling 0, dice stable, outcome per rules; 2-cycle roll_n glitch -> no state change.
- assert reset mid-ROLLING -> dice all 1, counts 0, win/loss 0, COME_OUT; 256 forced wins -> win_count saturates at 255.
